seg_scan_controller: RTL

Time-multiplexed scan controller for a common-select multi-digit seven-segment display. It holds a packed BCD word and cycles through the digits at a fixed dwell rate. Each digit's nibble goes through the existing `Encoder` decoder, and the controller drives one-hot digit selects and segment lines with an anti-ghosting blank gap. It sits between the register/CPU side, which loads new values through a valid/ready handshake, and the board display pins.

---
 rtl/seg_scan_controller_pkg.sv | 31 +++
 rtl/seg_scan_controller_if.sv | 22 ++
 rtl/seg_scan_controller_encoder.sv | 24 ++
 rtl/seg_scan_controller.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seg_scan_controller_pkg.sv
// Shared definitions for the seven-segment scan controller: segment constants,
// scan phase type, digit one-hot helper and parameter legality check.
package seg_scan_controller_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  typedef enum logic {
    SCAN_GAP = 1'b0,
    SCAN_LIT = 1'b1
  } scan_phase_e;

  // Callers truncate to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned i);
    logic [MAX_DIGITS-1:0] v;
    v = {MAX_DIGITS{1'b0}};
    if (i < MAX_DIGITS) begin
      v[i] = 1'b1;
    end else begin
      v = {MAX_DIGITS{1'b0}};
    end
    return v;
  endfunction

  function automatic bit params_ok(input int digits, input int dwell, input int blank);
    return (digits >= 2) && (digits <= MAX_DIGITS) && (dwell >= 4) &&
           (blank >= 1) && (blank < dwell);
  endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// Load-side valid/ready bus carrying a packed BCD word into the scan controller.
interface seg_scan_controller_if #(
  parameter int DIGITS = 4
) ();

  logic [4*DIGITS-1:0] in_value;
  logic                in_valid;
  logic                in_ready;

  modport master (
    output in_value,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_value,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/seg_scan_controller_encoder.sv
// BCD to seven-segment decoder (bit 0 = segment a); codes 10-15 light nothing.
module seg_scan_controller_encoder (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Segment pattern lookup.
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scan controller: double-buffered BCD word, per-digit
// dwell with a leading blank gap, optional leading-zero blanking, registered pins.
module seg_scan_controller
  import seg_scan_controller_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 8
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_controller_if.slave bus,
  input  logic                lz_blank,
  output logic [DIGITS-1:0]   digit_sel,
  output logic [6:0]          digital,
  output logic                frame_start
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(DWELL);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_LIT = CNT_W'(BLANK);

  if (!params_ok(DIGITS, DWELL, BLANK)) begin : g_bad_params
    $error("seg_scan_controller: illegal DIGITS/DWELL/BLANK combination");
  end

  logic [IDX_W-1:0]    idx_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [4*DIGITS-1:0] active_r;
  logic [4*DIGITS-1:0] shadow_r;
  logic                pending_r;
  logic [DIGITS-1:0]   digit_sel_r;
  logic [6:0]          digital_r;
  logic                frame_start_r;

  logic                wrap_s;
  logic [3:0]          nibble_s;
  logic [6:0]          seg_s;
  logic [DIGITS-1:0]   upper_nz_s;
  logic                blanked_s;
  scan_phase_e         phase_s;
  logic [DIGITS-1:0]   sel_next_s;
  logic [6:0]          seg_next_s;
  logic                fs_next_s;

  assign wrap_s        = (cnt_r == CNT_MAX) && (idx_r == IDX_MAX);
  assign bus.in_ready  = ~pending_r;
  assign digit_sel     = digit_sel_r;
  assign digital       = digital_r;
  assign frame_start   = frame_start_r;

  // Dwell counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= (idx_r == IDX_MAX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      idx_r <= idx_r;
    end
  end

  // Shadow load on handshake; commit to the displayed word only at frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r  <= {(4*DIGITS){1'b0}};
      active_r  <= {(4*DIGITS){1'b0}};
      pending_r <= 1'b0;
    end else if (pending_r && wrap_s) begin
      active_r  <= shadow_r;
      pending_r <= 1'b0;
    end else if (!pending_r && bus.in_valid) begin
      shadow_r  <= bus.in_value;
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Nibble of the digit currently being scanned.
  always_comb begin
    nibble_s = active_r[4*int'(idx_r) +: 4];
  end

  seg_scan_controller_encoder u_encoder (
    .bcd (nibble_s),
    .seg (seg_s)
  );

  // upper_nz_s[i] is set when any nibble at index >= i is nonzero.
  always_comb begin : p_upper_nz
    logic nz_acc;
    nz_acc     = 1'b0;
    upper_nz_s = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_acc        = nz_acc | (active_r[4*i +: 4] != 4'h0);
      upper_nz_s[i] = nz_acc;
    end
  end

  // Leading-zero blanking never applies to digit 0.
  always_comb begin
    if (lz_blank && (idx_r != {IDX_W{1'b0}})) begin
      blanked_s = ~upper_nz_s[idx_r];
    end else begin
      blanked_s = 1'b0;
    end
  end

  // Next values for the registered display pins.
  always_comb begin
    phase_s    = (cnt_r >= CNT_LIT) ? SCAN_LIT : SCAN_GAP;
    sel_next_s = {DIGITS{1'b0}};
    seg_next_s = SEG_OFF;
    fs_next_s  = (idx_r == {IDX_W{1'b0}}) && (cnt_r == {CNT_W{1'b0}});
    case (phase_s)
      SCAN_LIT: begin
        if (!blanked_s) begin
          sel_next_s = DIGITS'(onehot(int'(idx_r)));
          seg_next_s = seg_s;
        end else begin
          sel_next_s = {DIGITS{1'b0}};
          seg_next_s = SEG_OFF;
        end
      end
      default: begin
        sel_next_s = {DIGITS{1'b0}};
        seg_next_s = SEG_OFF;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_sel_r   <= {DIGITS{1'b0}};
      digital_r     <= SEG_OFF;
      frame_start_r <= 1'b0;
    end else begin
      digit_sel_r   <= sel_next_s;
      digital_r     <= seg_next_s;
      frame_start_r <= fs_next_s;
    end
  end

endmodule
